// File: rtl/wb_sram_slave.sv
// Wishbone classic-pipelined slave in front of a single-port word memory.
// Requests queue in a 2-entry FIFO behind a service register; one ack per request, in order.
module wb_sram_slave #(
  parameter int unsigned adr_width     = 16,
  parameter int unsigned dat_width     = 16,
  parameter int unsigned mem_adr_width = 10,
  parameter int unsigned wait_states   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cyc,
  input  logic                 stb,
  input  logic                 we,
  input  logic [adr_width-1:0] adr,
  input  logic [dat_width-1:0] dat_i,
  output logic [dat_width-1:0] dat_o,
  output logic                 ack,
  output logic                 stall
);

  localparam int unsigned Depth    = 2 ** mem_adr_width;
  localparam logic [1:0]  WcntInit = 2'(wait_states);

  typedef struct packed {
    logic                     we;
    logic [mem_adr_width-1:0] adr;
    logic [dat_width-1:0]     dat;
  } req_t;

  typedef enum logic {StIdle, StWait} state_e;

  state_e               state_q, state_d;
  req_t                 svc_q, svc_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 ack_q, ack_d;
  logic [dat_width-1:0] dat_q, dat_d;

  req_t                 fifo_q [2];
  logic [dat_width-1:0] mem_q [Depth];

  req_t incoming;
  logic push, pop, bypass, done, free, fifo_we, mem_we;

  assign incoming = {we, adr[mem_adr_width-1:0], dat_i};
  assign stall    = (count_q == 2'd2);
  assign ack      = ack_q;
  assign dat_o    = dat_q;

  // Address bits above the memory index alias onto the same words.
  if (adr_width > mem_adr_width) begin : g_unused_adr
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr[adr_width-1:mem_adr_width];
  end

  always_comb begin
    state_d  = state_q;
    svc_d    = svc_q;
    wcnt_d   = wcnt_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ack_d    = 1'b0;
    dat_d    = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    fifo_we  = 1'b0;
    mem_we   = 1'b0;
    push     = cyc & stb & ~stall;
    done     = (state_q == StWait) && (wcnt_q == 2'd0);
    free     = (state_q == StIdle) || done;

    if (rst || !cyc) begin
      // Abort: drop everything not yet acked, including a completion due on this edge.
      state_d  = StIdle;
      wcnt_d   = '0;
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if ((state_q == StWait) && !done) begin
        wcnt_d = wcnt_q - 2'd1;
      end
      if (done) begin
        ack_d  = 1'b1;
        mem_we = svc_q.we;
        if (!svc_q.we) begin
          dat_d = mem_q[svc_q.adr];
        end
      end
      // A free server takes the FIFO head, or the incoming request directly when empty.
      if (free) begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          svc_d   = fifo_q[rd_ptr_q];
          state_d = StWait;
          wcnt_d  = WcntInit;
        end else if (push) begin
          bypass  = 1'b1;
          svc_d   = incoming;
          state_d = StWait;
          wcnt_d  = WcntInit;
        end else begin
          state_d = StIdle;
        end
      end
      fifo_we = push & ~bypass;
      if (fifo_we) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (fifo_we && !pop) begin
        count_d = count_q + 2'd1;
      end else if (!fifo_we && pop) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      svc_q    <= '0;
      wcnt_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      svc_q    <= svc_d;
      wcnt_q   <= wcnt_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_q[wr_ptr_q] <= incoming;
    end
    if (mem_we) begin
      mem_q[svc_q.adr] <= svc_q.dat;
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: four instances with wait_states 0..3,
// directed vectors and corner sequences, then random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_wb_sram_slave;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [NI];
  logic        stb   [NI];
  logic        we    [NI];
  logic [15:0] adr   [NI];
  logic [15:0] dat_i [NI];
  logic [15:0] dat_o [NI];
  logic        ack   [NI];
  logic        stall [NI];

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [NI][1024];

  typedef struct {
    int          k;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          lat;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    logic        w;
    int          a;
    logic [15:0] d;
    int          st;
    int          ak;
  } pend_t;

  pend_t pq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_sram_slave #(
      .adr_width(16), .dat_width(16), .mem_adr_width(10), .wait_states(g)
    ) u_dut (
      .clk(clk), .rst(rst), .cyc(cyc[g]), .stb(stb[g]), .we(we[g]), .adr(adr[g]),
      .dat_i(dat_i[g]), .dat_o(dat_o[g]), .ack(ack[g]), .stall(stall[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated request; lat = negedges after the accepting edge until ack is seen.
  task automatic single(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd);
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_i[k] = d;
    @(posedge clk); #1;
    stb[k] = 1'b0;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack[k]) begin
        lat = i;
        rd  = dat_o[k];
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      chk($sformatf("ack_width_k%0d", k), 32'(ack[k]), 32'd0);
      if (w) ref_mem[k][a[9:0]] = d;
    end
  endtask

  task automatic rand_run(input int k, input int ncyc);
    int          e;
    int          last_ak;
    int          nwait;
    bit          abort_pend;
    bit          c;
    bit          s;
    logic        exp_ack;
    logic        exp_stall;
    logic [15:0] exp_dat;
    pend_t       p;
    e = 0;
    last_ak = 0;
    abort_pend = 1'b0;
    pq.delete();
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); e++; #1;
      exp_ack = 1'b0;
      exp_dat = '0;
      if (abort_pend) begin
        pq.delete();
        last_ak = 0;
      end else if (pq.size() > 0 && pq[0].ak == e) begin
        exp_ack = 1'b1;
        if (pq[0].w) ref_mem[k][pq[0].a] = pq[0].d;
        else exp_dat = ref_mem[k][pq[0].a];
        void'(pq.pop_front());
      end
      nwait = 0;
      foreach (pq[i]) if (pq[i].st > e) nwait++;
      exp_stall = (nwait == 2);
      c = ($urandom_range(0, 24) != 0);
      s = ($urandom_range(0, 3) != 0);
      cyc[k] = c; stb[k] = s; we[k] = 1'($urandom_range(0, 1));
      adr[k] = {6'($urandom), 6'd0, 4'($urandom)};
      dat_i[k] = 16'($urandom);
      if (c && s && !exp_stall) begin
        p.w  = we[k];
        p.a  = int'(adr[k][9:0]);
        p.d  = dat_i[k];
        p.st = (last_ak > e + 1) ? last_ak : e + 1;
        p.ak = p.st + k + 1;
        last_ak = p.ak;
        pq.push_back(p);
      end
      abort_pend = !c;
      @(negedge clk);
      chk($sformatf("rnd_k%0d_n%0d_ack", k, n), 32'(ack[k]), 32'(exp_ack));
      chk($sformatf("rnd_k%0d_n%0d_stall", k, n), 32'(stall[k]), 32'(exp_stall));
      chk($sformatf("rnd_k%0d_n%0d_dat", k, n), 32'(dat_o[k]), 32'(exp_dat));
    end
    @(posedge clk); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  initial begin
    vec_t        vecs [10];
    int          lat;
    logic [15:0] rd;
    int          acc_n;
    int          first_stall;
    int          ack_cyc[$];
    int          abort_acks;
    logic        exp_ack;
    logic [15:0] exp_d;

    vecs[0] = '{1, 1'b1, 16'h0012, 16'hBEEF, 2, 16'h0000};
    vecs[1] = '{1, 1'b0, 16'h0012, 16'h0000, 2, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 16'h0405, 16'hA5A5, 2, 16'h0000};
    vecs[3] = '{1, 1'b0, 16'h0005, 16'h0000, 2, 16'hA5A5};
    vecs[4] = '{1, 1'b1, 16'hFFFF, 16'h1234, 2, 16'h0000};
    vecs[5] = '{1, 1'b0, 16'h03FF, 16'h0000, 2, 16'h1234};
    vecs[6] = '{0, 1'b1, 16'h0007, 16'h0F0F, 1, 16'h0000};
    vecs[7] = '{0, 1'b0, 16'h8007, 16'h0000, 1, 16'h0F0F};
    vecs[8] = '{3, 1'b1, 16'h0100, 16'hCAFE, 4, 16'h0000};
    vecs[9] = '{3, 1'b0, 16'h0500, 16'h0000, 4, 16'hCAFE};

    for (int k = 0; k < NI; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; dat_i[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_ack_k%0d", k), 32'(ack[k]), 32'd0);
      chk($sformatf("reset_stall_k%0d", k), 32'(stall[k]), 32'd0);
      chk($sformatf("reset_dat_k%0d", k), 32'(dat_o[k]), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      single(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].d, lat, rd);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_dat", i), 32'(rd), 32'(vecs[i].rd));
    end

    // Pipelined burst, wait_states=0.
    for (int i = 0; i < 4; i++) begin
      single(0, 1'b1, 16'(i), 16'(16'h1111 * (i + 1)), lat, rd);
      chk($sformatf("burst_pre%0d_lat", i), 32'(lat), 32'd1);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c < 4) begin
        stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 16'(c);
      end else begin
        stb[0] = 1'b0;
      end
      @(negedge clk);
      exp_ack = (c >= 2 && c <= 5);
      exp_d   = exp_ack ? 16'(16'h1111 * (c - 1)) : 16'h0000;
      chk($sformatf("burst_c%0d_stall", c), 32'(stall[0]), 32'd0);
      chk($sformatf("burst_c%0d_ack", c), 32'(ack[0]), 32'(exp_ack));
      chk($sformatf("burst_c%0d_dat", c), 32'(dat_o[0]), 32'(exp_d));
    end

    // Backpressure, wait_states=3.
    acc_n = 0;
    first_stall = -1;
    cyc[3] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      stb[3] = (acc_n < 6); we[3] = 1'b1;
      adr[3] = 16'(16'h0020 + acc_n); dat_i[3] = 16'(16'h7000 + acc_n);
      @(negedge clk);
      if (stall[3] && first_stall < 0) first_stall = c;
      if (stb[3] && !stall[3]) acc_n++;
      if (ack[3]) ack_cyc.push_back(c);
    end
    stb[3] = 1'b0;
    chk("bp_accepted", 32'(acc_n), 32'd6);
    chk("bp_acks", 32'(ack_cyc.size()), 32'd6);
    chk("bp_first_stall", 32'(first_stall), 32'd3);
    if (ack_cyc.size() > 0) chk("bp_first_ack", 32'(ack_cyc[0]), 32'd5);
    for (int i = 1; i < ack_cyc.size(); i++) begin
      chk($sformatf("bp_spacing%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
    end

    // Abort, wait_states=2.
    single(2, 1'b1, 16'h0001, 16'h1234, lat, rd);
    chk("abort_pre1_lat", 32'(lat), 32'd3);
    single(2, 1'b1, 16'h0002, 16'h2345, lat, rd);
    single(2, 1'b1, 16'h0003, 16'h3456, lat, rd);
    abort_acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 16'(i + 1); dat_i[2] = 16'(16'h5555 + 16'h1111 * i);
      @(negedge clk);
      if (ack[2]) abort_acks++;
    end
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(negedge clk);
    chk("abort_stall_full", 32'(stall[2]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) cyc[2] = 1'b1;
      @(negedge clk);
      if (ack[2]) abort_acks++;
      chk($sformatf("abort_stall%0d", i), 32'(stall[2]), 32'd0);
    end
    chk("abort_no_ack", 32'(abort_acks), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      single(2, 1'b0, 16'(i), 16'h0000, lat, rd);
      chk($sformatf("abort_rd%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("abort_rd%0d_dat", i), 32'(rd), 32'(16'h1234 + 16'h1111 * (i - 1)));
    end

    // Random traffic with aborts against the model.
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 16; a++) begin
        single(k, 1'b1, 16'(a), 16'($urandom), lat, rd);
        chk($sformatf("rpre_k%0d_a%0d_lat", k, a), 32'(lat), 32'(k + 1));
      end
      rand_run(k, 400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
